dmem_sram_responder: RTL and testbench
======================================

Name: dmem_sram_responder

Overview:
- Data-memory responder on the far side of the MEM-stage load/store interface.
- Owns a single-port, word-wide synchronous SRAM array with no byte enables.
- Serves word, halfword and byte requests. Sub-word stores are done as an internal read-modify-write.
- Raises a stall so the MEM stage holds its request until the access completes.

Parameters:
- ADDR_W, 10, word-index width; array depth is 2**ADDR_W 32-bit words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- ce_i  input  1  request valid; held stable by the requester while stall_o=1.
- we_i  input  1  1=store, 0=load; meaningful only when ce_i=1.
- size_i  input  2  access size: 00=byte, 01=halfword, 10=word; 11 is illegal and treated as misaligned.
- addr_i  input  32  byte address; word index = addr_i[ADDR_W+1:2]; higher bits ignored, so the array wraps.
- wdata_i  input  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- rdata_o  output  32  raw 32-bit word read; the requester extracts lanes.
- stall_o  output  1  1 = requester must hold its request and freeze.
- err_o  output  1  misaligned or illegal-size request present this cycle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Endianness is little: byte lane k = bits [8k+7:8k], and k = addr_i[1:0].
- Reset values (resetn=0 at an edge):
  - state=IDLE, rdata_o=0.
  - stall_o and err_o forced 0 while resetn=0.
  - Array contents are not cleared.
- Misalignment rule: size 01 with addr_i[0]=1, size 10 with addr_i[1:0]!=0, or size 11.
  - err_o=1 combinationally; stall_o=0.
  - No array write; rdata_o unchanged; state stays IDLE.
- States: IDLE, RD, MERGE, DONE.
- IDLE:
  - ce_i=0: idle; stall_o=0.
  - Aligned word store: write wdata_i to the array at the edge; stall_o=0; stay IDLE. Single-cycle, no stall.
  - Aligned load: stall_o=1; array read issued; next state RD.
  - Aligned byte or halfword store: stall_o=1; array read issued; latch lane offset, size and wdata; next state MERGE.
- RD:
  - rdata_o <= array word at the edge; stall_o=1; next state DONE.
  - rdata_o becomes visible in DONE.
- MERGE:
  - stall_o=1.
  - Merged word = read word with the target lane(s) replaced by the shifted store data:
    - byte: wdata[7:0] placed at lane k;
    - halfword: wdata[15:0] placed at lanes {addr[1],0}.
  - Merged word written at the edge; next state DONE.
- DONE:
  - stall_o=0; request is consumed.
  - Inputs are ignored this cycle, so the held request does not re-trigger.
  - Unconditionally returns to IDLE.
  - rdata_o holds its value until the next load's RD.
- Latency:
  - word store: 1 cycle, no stall;
  - load: 3 cycles (stall high 2 cycles, data valid in the 3rd);
  - sub-word store: 3 cycles (stall high 2 cycles).
- Back-to-back: a new request may be presented in the cycle after DONE; there are no bubbles beyond DONE.
- Read-after-write: a load following a sub-word store sees the merged word. Array ordering guarantees this; no bypass is required.
- Reset mid-operation: resetn=0 in RD or MERGE aborts the access.
  - A pending MERGE write is suppressed; the array keeps its pre-request value.
  - State returns to IDLE.
- ce_i dropping while stall_o=1 is a protocol violation. The state machine still completes its sequence; the array result is defined by the latched values.

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x10, then load 0x10. Required: no stall on the store; stall_o=1,1,0 for the load; rdata_o=0xDEADBEEF in DONE.
- Byte merge: word 0x11223344 at addr 0x20, then store byte wdata_i=0x000000AB at addr 0x22. Required: stall 2 cycles; a subsequent load returns 0x11AB3344.
- Halfword merge: word 0x11223344 at addr 0x30, then store halfword 0xBEEF at addr 0x32. Required: load returns 0xBEEF3344. Repeat at addr 0x30 -> 0x1122BEEF.
- Misaligned requests: halfword store at 0x41, word load at 0x42, size 11 at 0x40. Required: err_o=1, stall_o=0, array word 0x40 unchanged, rdata_o unchanged.
- Reset mid-operation: byte store 0xFF to addr 0x50 (word 0x00000000); resetn=0 during MERGE. Required: state IDLE, stall_o=0, rdata_o=0; a later load of 0x50 returns 0x00000000.
- Wrap-around and back-to-back: with ADDR_W=10, store 0x5A5A5A5A at 0x00001000, then immediately load 0x00000000 in the cycle after the store. Required: rdata_o=0x5A5A5A5A; no extra idle cycle between requests.

Source files
------------

// File: rtl/dmem_sram_responder_if.sv
// Load/store request bus between the MEM stage (master) and the data-memory
// responder (slave).
interface dmem_sram_responder_if;
  logic        ce_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output ce_i, we_i, size_i, addr_i, wdata_i,
    input  rdata_o, stall_o, err_o
  );

  modport slave (
    input  ce_i, we_i, size_i, addr_i, wdata_i,
    output rdata_o, stall_o, err_o
  );
endinterface

// File: rtl/dmem_sram_responder.sv
// Data-memory responder: word-wide synchronous SRAM serving word/half/byte
// accesses, with sub-word stores done as a stalled read-modify-write.
module dmem_sram_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  dmem_sram_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, MERGE, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_mem [2**ADDR_W];
  logic [31:0]         r_rd_word;
  logic [31:0]         r_rdata;
  logic [31:0]         r_wdata;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_lane;
  logic                r_half;

  logic [ADDR_W-1:0]   w_idx;
  logic                w_misal;
  logic                w_stall;
  logic                w_err;
  logic                w_rd_en;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_widx;
  logic [31:0]         w_mem_wdata;
  logic [4:0]          w_shift;
  logic [31:0]         w_mask;
  logic [31:0]         w_merged;
  logic                w_unused_addr;

  assign w_idx         = bus.addr_i[ADDR_W+1:2];
  assign w_unused_addr = ^bus.addr_i[31:ADDR_W+2];

  assign w_misal = ((bus.size_i == 2'b01) && bus.addr_i[0])
                || ((bus.size_i == 2'b10) && (bus.addr_i[1:0] != 2'b00))
                ||  (bus.size_i == 2'b11);

  // r_lane already holds the halfword-aligned lane, so one shift serves both sizes
  assign w_shift  = {r_lane, 3'b000};
  assign w_mask   = r_half ? (32'h0000FFFF << w_shift) : (32'h000000FF << w_shift);
  assign w_merged = (r_rd_word & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_err       = 1'b0;
    w_rd_en     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_widx  = w_idx;
    w_mem_wdata = bus.wdata_i;
    case (r_state)
      IDLE: begin
        if (bus.ce_i) begin
          if (w_misal) begin
            w_err = 1'b1;
          end else if (bus.we_i && (bus.size_i == 2'b10)) begin
            w_mem_we = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_rd_en = 1'b1;
            w_next  = bus.we_i ? MERGE : RD;
          end
        end
      end
      RD: begin
        w_stall = 1'b1;
        w_next  = DONE;
      end
      MERGE: begin
        w_stall     = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_widx  = r_idx;
        w_mem_wdata = w_merged;
        w_next      = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset also suppresses a pending MERGE write so the array keeps its old word
    if (!resetn) begin
      w_next   = IDLE;
      w_stall  = 1'b0;
      w_err    = 1'b0;
      w_rd_en  = 1'b0;
      w_mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RD) r_rdata <= r_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_rd_word <= r_mem[w_idx];
      r_idx     <= w_idx;
      r_half    <= bus.size_i[0];
      r_lane    <= bus.size_i[0] ? {bus.addr_i[1], 1'b0} : bus.addr_i[1:0];
      r_wdata   <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_widx] <= w_mem_wdata;
  end

  assign bus.rdata_o = r_rdata;
  assign bus.stall_o = w_stall;
  assign bus.err_o   = w_err;

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Self-checking bench for dmem_sram_responder against a byte-addressed
// memory model.
module tb_dmem_sram_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  dmem_sram_responder_if bus();

  dmem_sram_responder #(.ADDR_W(10)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // 2**10 words = 4096 bytes; byte address wraps modulo that size
  logic [7:0]  mem_b [4096];
  logic [31:0] exp_rdata;
  logic [31:0] known_addr [16];

  function automatic int unsigned baddr(input logic [31:0] addr);
    return int'(addr % 32'd4096);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int unsigned a;
    a = baddr(addr) & ~32'd3;
    return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
  endfunction

  function automatic bit model_misal(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr[0];
      2'd2:    return addr[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned a;
    int unsigned n;
    a = baddr(addr);
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int unsigned i = 0; i < n; i++) mem_b[a+i] = wd[8*i +: 8];
  endtask

  task automatic idle();
    bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00;
    bus.addr_i = '0; bus.wdata_i = '0;
  endtask

  // Presents one request at a negedge and walks it to completion; returns at
  // the negedge where the next request may be presented.
  task automatic req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wd, input string tag);
    bit mis;
    mis = model_misal(size, addr);
    bus.ce_i = 1'b1; bus.we_i = we; bus.size_i = size;
    bus.addr_i = addr; bus.wdata_i = wd;
    #1;
    n_cmp++;
    if (bus.err_o !== mis) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b (addr %h size %0d)", tag, bus.err_o, mis, addr, size);
    end
    if (mis || (we && size == 2'd2)) begin
      n_cmp++;
      if (bus.stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall0: got %b want 0", tag, bus.stall_o);
      end
      @(negedge clk);
      if (mis) begin
        n_cmp++;
        if (bus.rdata_o !== exp_rdata) begin
          n_fail++;
          $display("FAIL %s rdata_hold: got %h want %h", tag, bus.rdata_o, exp_rdata);
        end
      end else begin
        model_store(size, addr, wd);
      end
    end else begin
      n_cmp++;
      if (bus.stall_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s stall_c1: got %b want 1", tag, bus.stall_o);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.stall_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s stall_c2: got %b want 1", tag, bus.stall_o);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall_done: got %b want 0", tag, bus.stall_o);
      end
      if (!we) begin
        exp_rdata = model_word(addr);
        n_cmp++;
        if (bus.rdata_o !== exp_rdata) begin
          n_fail++;
          $display("FAIL %s rdata: got %h want %h (addr %h)", tag, bus.rdata_o, exp_rdata, addr);
        end
      end else begin
        model_store(size, addr, wd);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.size_i = 2'b11; bus.addr_i = 32'h40;
    #1;
    n_cmp++;
    if (bus.err_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_forced: got err %b stall %b want 0 0", bus.err_o, bus.stall_o);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want 00000000", bus.rdata_o);
    end
    exp_rdata = '0;
  endtask

  task automatic test_word_store_load();
    req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, "ws_store");
    req(1'b0, 2'd2, 32'h10, 32'h0, "ws_load");
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.rdata_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ws_hold: got %h want deadbeef", bus.rdata_o);
    end
  endtask

  task automatic test_byte_merge();
    req(1'b1, 2'd2, 32'h20, 32'h11223344, "bm_init");
    req(1'b1, 2'd0, 32'h22, 32'h000000AB, "bm_store");
    req(1'b0, 2'd2, 32'h20, 32'h0, "bm_load");
    n_cmp++;
    if (bus.rdata_o !== 32'h11AB3344) begin
      n_fail++;
      $display("FAIL bm_value: got %h want 11ab3344", bus.rdata_o);
    end
    idle();
  endtask

  task automatic test_half_merge();
    req(1'b1, 2'd2, 32'h30, 32'h11223344, "hm_init");
    req(1'b1, 2'd1, 32'h32, 32'h0000BEEF, "hm_store_hi");
    req(1'b0, 2'd2, 32'h30, 32'h0, "hm_load_hi");
    n_cmp++;
    if (bus.rdata_o !== 32'hBEEF3344) begin
      n_fail++;
      $display("FAIL hm_hi_value: got %h want beef3344", bus.rdata_o);
    end
    req(1'b1, 2'd2, 32'h30, 32'h11223344, "hm_reinit");
    req(1'b1, 2'd1, 32'h30, 32'h0000BEEF, "hm_store_lo");
    req(1'b0, 2'd2, 32'h30, 32'h0, "hm_load_lo");
    n_cmp++;
    if (bus.rdata_o !== 32'h1122BEEF) begin
      n_fail++;
      $display("FAIL hm_lo_value: got %h want 1122beef", bus.rdata_o);
    end
    idle();
  endtask

  task automatic test_misaligned();
    req(1'b1, 2'd2, 32'h40, 32'hCAFEF00D, "mis_init");
    req(1'b0, 2'd2, 32'h10, 32'h0, "mis_prime");
    req(1'b1, 2'd1, 32'h41, 32'h00001234, "mis_half");
    req(1'b0, 2'd2, 32'h42, 32'h0, "mis_word");
    req(1'b1, 2'd3, 32'h40, 32'hFFFFFFFF, "mis_size3");
    req(1'b0, 2'd2, 32'h40, 32'h0, "mis_check");
    n_cmp++;
    if (bus.rdata_o !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL mis_unchanged: got %h want cafef00d", bus.rdata_o);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    req(1'b1, 2'd2, 32'h50, 32'h0, "rm_init");
    bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'd0;
    bus.addr_i = 32'h50; bus.wdata_i = 32'hFF;
    @(negedge clk);
    n_cmp++;
    if (bus.stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_in_merge: got stall %b want 1", bus.stall_o);
    end
    resetn = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (bus.stall_o !== 1'b0 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_forced: got stall %b err %b want 0 0", bus.stall_o, bus.err_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rdata_o !== 32'h0 || bus.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_after: got rdata %h stall %b want 00000000 0", bus.rdata_o, bus.stall_o);
    end
    exp_rdata = '0;
    resetn = 1'b1;
    req(1'b0, 2'd2, 32'h50, 32'h0, "rm_load");
    idle();
  endtask

  task automatic test_back_to_back();
    req(1'b1, 2'd2, 32'h00001000, 32'h5A5A5A5A, "b2b_store");
    req(1'b0, 2'd2, 32'h00000000, 32'h0, "b2b_load");
    n_cmp++;
    if (bus.rdata_o !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL b2b_wrap: got %h want 5a5a5a5a", bus.rdata_o);
    end
    req(1'b0, 2'd2, 32'h10, 32'h0, "b2b_load2");
    req(1'b1, 2'd0, 32'h13, 32'h00000077, "b2b_byte");
    req(1'b0, 2'd2, 32'h10, 32'h0, "b2b_raw");
    idle();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    for (int unsigned i = 0; i < 16; i++) begin
      known_addr[i] = ($urandom & 32'hFFFF_C000) | (32'(i) << 6);
      req(1'b1, 2'd2, known_addr[i], $urandom, "rnd_init");
    end
    for (int unsigned n = 0; n < 300; n++) begin
      a  = known_addr[$urandom_range(15, 0)];
      a  = (a & 32'h0000_3FFC) | ($urandom & 32'hFFFF_C000) | 32'($urandom_range(3, 0));
      sz = 2'($urandom_range(3, 0));
      req(1'($urandom_range(1, 0)), sz, a, $urandom, "rnd_op");
      if ($urandom_range(3, 0) == 0) begin
        idle();
        @(negedge clk);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_word_store_load();
    test_byte_merge();
    test_half_merge();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
